// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, sequencer states, and default widths.
// Used by alu_op_sequencer and by the UART parser/serializer that surround it.
package alu_pkg;

  localparam int unsigned ALU_DATA_WIDTH  = 32;
  localparam int unsigned ALU_COUNT_WIDTH = 16;
  localparam int unsigned ALU_OP_WIDTH    = 8;

  // Command opcodes carried in the UART packet header
  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ADD  = 8'h01,
    MUL  = 8'h02,
    DIV  = 8'h03,
    ECHO = 8'hEC
  } opcode_e;

  // Sequencer control states
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_FIRST = 3'd1,
    LOAD_NEXT  = 3'd2,
    ISSUE      = 3'd3,
    WAIT_RSP   = 3'd4,
    DRAIN      = 3'd5,
    RESULT     = 3'd6
  } seq_state_e;

  // Accumulator value substituted when a divisor of zero is seen
  localparam logic [ALU_DATA_WIDTH-1:0] DIV_BY_ZERO_RESULT = '1;

  // True for opcodes the sequencer folds
  function automatic logic is_arith_op(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ADD) || (op == MUL) || (op == DIV);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-operand ALU command sequencer.
// Accepts {opcode, count}, streams count operands and folds them left-to-right
// into an accumulator. ADD folds locally; MUL/DIV steps go to an external shared
// iterative mul/div unit over a req/rsp handshake. Result goes out on res_*.
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   cmd_valid_i/ready_o/op_i/count_i   command from the packet parser
//   opnd_valid_i/ready_o/data_i        operand stream
//   req_valid_o/ready_i/div_o/a_o/b_o  request to the mul/div unit
//   rsp_valid_i/data_i                 single-cycle response from the unit
//   res_valid_o/ready_i/data_o/err_o   result to the TX serializer
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = ALU_DATA_WIDTH,
  parameter int unsigned COUNT_WIDTH = ALU_COUNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [ALU_OP_WIDTH-1:0] cmd_op_i,
  input  logic [COUNT_WIDTH-1:0] cmd_count_i,
  input  logic                   opnd_valid_i,
  output logic                   opnd_ready_o,
  input  logic [DATA_WIDTH-1:0]  opnd_data_i,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic                   req_div_o,
  output logic [DATA_WIDTH-1:0]  req_a_o,
  output logic [DATA_WIDTH-1:0]  req_b_o,
  input  logic                   rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]  rsp_data_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [DATA_WIDTH-1:0]  res_data_o,
  output logic                   res_err_o
);

  seq_state_e               state_q, state_d;
  logic [DATA_WIDTH-1:0]    acc_q, acc_d;
  logic [DATA_WIDTH-1:0]    req_b_q, req_b_d;
  logic [COUNT_WIDTH-1:0]   rem_q, rem_d;
  logic [ALU_OP_WIDTH-1:0]  op_q, op_d;
  logic                     err_q, err_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     opnd_ready_q, opnd_ready_d;
  logic                     req_valid_q, req_valid_d;
  logic                     req_div_q, req_div_d;
  logic                     res_valid_q, res_valid_d;

  logic cmd_fire, opnd_fire, req_fire, res_fire, last_opnd;

  assign cmd_fire  = cmd_valid_i & cmd_ready_q;
  assign opnd_fire = opnd_valid_i & opnd_ready_q;
  assign req_fire  = req_valid_q & req_ready_i;
  assign res_fire  = res_valid_q & res_ready_i;
  assign last_opnd = (rem_q == COUNT_WIDTH'(1));

  // Next-state, datapath and next-output decode
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    req_b_d = req_b_q;
    rem_d   = rem_q;
    op_d    = op_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          op_d  = cmd_op_i;
          rem_d = cmd_count_i;
          err_d = 1'b0;
          if (cmd_count_i == '0) begin
            acc_d   = '0;
            state_d = RESULT;
          end else if (!is_arith_op(cmd_op_i)) begin
            acc_d   = '0;
            err_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = LOAD_FIRST;
          end
        end
      end

      LOAD_FIRST: begin
        if (opnd_fire) begin
          acc_d   = opnd_data_i;
          rem_d   = rem_q - COUNT_WIDTH'(1);
          state_d = last_opnd ? RESULT : LOAD_NEXT;
        end
      end

      LOAD_NEXT: begin
        if (opnd_fire) begin
          rem_d = rem_q - COUNT_WIDTH'(1);
          if (op_q == ADD) begin
            acc_d   = acc_q + opnd_data_i;
            state_d = last_opnd ? RESULT : LOAD_NEXT;
          end else if ((op_q == DIV) && (opnd_data_i == '0)) begin
            // Divide by zero saturates locally; the unit never sees it
            acc_d   = DATA_WIDTH'(DIV_BY_ZERO_RESULT);
            err_d   = 1'b1;
            state_d = last_opnd ? RESULT : LOAD_NEXT;
          end else begin
            req_b_d = opnd_data_i;
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (req_fire) state_d = WAIT_RSP;
      end

      WAIT_RSP: begin
        if (rsp_valid_i) begin
          acc_d   = rsp_data_i;
          state_d = (rem_q == '0) ? RESULT : LOAD_NEXT;
        end
      end

      DRAIN: begin
        if (opnd_fire) begin
          rem_d = rem_q - COUNT_WIDTH'(1);
          if (last_opnd) state_d = RESULT;
        end
      end

      RESULT: begin
        if (res_fire) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered from the next state
    cmd_ready_d  = (state_d == IDLE);
    opnd_ready_d = (state_d == LOAD_FIRST) || (state_d == LOAD_NEXT) ||
                   (state_d == DRAIN);
    req_valid_d  = (state_d == ISSUE);
    res_valid_d  = (state_d == RESULT);
    req_div_d    = (op_d == DIV);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      req_b_q      <= '0;
      rem_q        <= '0;
      op_q         <= '0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b0;
      opnd_ready_q <= 1'b0;
      req_valid_q  <= 1'b0;
      req_div_q    <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      req_b_q      <= req_b_d;
      rem_q        <= rem_d;
      op_q         <= op_d;
      err_q        <= err_d;
      cmd_ready_q  <= cmd_ready_d;
      opnd_ready_q <= opnd_ready_d;
      req_valid_q  <= req_valid_d;
      req_div_q    <= req_div_d;
      res_valid_q  <= res_valid_d;
    end
  end

  // acc is stable in ISSUE and RESULT, so it drives both req_a and res_data
  assign cmd_ready_o  = cmd_ready_q;
  assign opnd_ready_o = opnd_ready_q;
  assign req_valid_o  = req_valid_q;
  assign req_div_o    = req_div_q;
  assign req_a_o      = acc_q;
  assign req_b_o      = req_b_q;
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = acc_q;
  assign res_err_o    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural mul/div unit.
module tb_alu_op_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_op = '0;
  logic [15:0] cmd_count = '0;
  logic        opnd_valid = 1'b0;
  logic [31:0] opnd_data = '0;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        res_ready = 1'b1;

  logic        cmd_ready_o, opnd_ready_o, req_valid_o, req_div_o;
  logic        res_valid_o, res_err_o;
  logic [31:0] req_a_o, req_b_o, res_data_o;

  alu_op_sequencer dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op),
    .cmd_count_i  (cmd_count),
    .opnd_valid_i (opnd_valid),
    .opnd_ready_o (opnd_ready_o),
    .opnd_data_i  (opnd_data),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready),
    .req_div_o    (req_div_o),
    .req_a_o      (req_a_o),
    .req_b_o      (req_b_o),
    .rsp_valid_i  (rsp_valid),
    .rsp_data_i   (rsp_data),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data_o),
    .res_err_o    (res_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_req = 0;
  int   req_stall = 0;
  int   rsp_lat = 4;
  logic [31:0] last_a = '0, last_b = '0;
  logic        last_div = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every result handshake against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!reset_i && res_valid_o && res_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %h err %0b expected none", res_data_o, res_err_o);
        end else begin
          e = sb.pop_front();
          chk("res_data", res_data_o, e.data);
          chk("res_err", 32'(res_err_o), 32'(e.err));
        end
      end
    end
  end

  // Behavioural shared mul/div unit with programmable stall and latency
  initial begin
    logic [31:0] a, b;
    logic        d, aborted;
    forever begin
      @(posedge clk_i); #1;
      rsp_valid = 1'b0;
      if (req_valid_o && !reset_i) begin
        a = req_a_o; b = req_b_o; d = req_div_o;
        last_a = a; last_b = b; last_div = d;
        n_req++;
        if (d) chk("div_zero_issued", 32'(b == 0), 32'd0);
        for (int k = 0; k < req_stall; k++) begin
          @(posedge clk_i); #1;
          chk("stall_req_valid", 32'(req_valid_o), 32'd1);
          chk("stall_req_a", req_a_o, a);
          chk("stall_req_b", req_b_o, b);
        end
        req_ready = 1'b1;
        @(posedge clk_i); #1;
        req_ready = 1'b0;
        aborted = 1'b0;
        for (int k = 1; k < rsp_lat; k++) begin
          @(posedge clk_i);
          if (reset_i) aborted = 1'b1;
          #1;
          if (aborted) break;
        end
        if (!aborted) begin
          rsp_data  = d ? (a / b) : 32'(a * b);
          rsp_valid = 1'b1;
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] op, input logic [15:0] cnt);
    logic hs;
    int   n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
    do begin
      @(negedge clk_i); hs = cmd_ready_o;
      @(posedge clk_i); #1; n++;
    end while (!hs && n < 200);
    if (!hs) chk("cmd_handshake_timeout", 32'(hs), 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic send_opnd(input logic [31:0] data);
    logic hs;
    int   n = 0;
    opnd_valid = 1'b1; opnd_data = data;
    do begin
      @(negedge clk_i); hs = opnd_ready_o;
      @(posedge clk_i); #1; n++;
    end while (!hs && n < 200);
    if (!hs) chk("opnd_handshake_timeout", 32'(hs), 32'd1);
    opnd_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] data, input logic err);
    exp_t e;
    e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk_i); #1; n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, r0;

    // Reset values
    repeat (2) @(posedge clk_i); #1;
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    chk("rst_opnd_ready", 32'(opnd_ready_o), 32'd0);
    chk("rst_req_valid", 32'(req_valid_o), 32'd0);
    chk("rst_res_valid", 32'(res_valid_o), 32'd0);
    chk("rst_res_data", res_data_o, 32'd0);
    chk("rst_req_a", req_a_o, 32'd0);
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);

    // ADD 5 + 7 + 0xFFFFFFFF wraps to 0xB, one operand per cycle
    push_exp(32'h0000000B, 1'b0);
    send_cmd(8'h01, 16'd3);
    c0 = cyc;
    send_opnd(32'd5);
    send_opnd(32'd7);
    send_opnd(32'hFFFFFFFF);
    chk("add_throughput_cycles", 32'(cyc - c0), 32'd3);
    wait_drain();

    // MUL 0x10000 * 0x10000 truncates to 0, unit stalls 3 cycles then latency 8
    req_stall = 3; rsp_lat = 8; r0 = n_req;
    push_exp(32'h00000000, 1'b0);
    send_cmd(8'h02, 16'd2);
    send_opnd(32'h00010000);
    send_opnd(32'h00010000);
    wait_drain();
    chk("mul_req_count", 32'(n_req - r0), 32'd1);
    chk("mul_req_a", last_a, 32'h00010000);
    chk("mul_req_b", last_b, 32'h00010000);
    chk("mul_req_div", 32'(last_div), 32'd0);

    // DIV 100 / 0 / 3: zero divisor handled locally, then 0xFFFFFFFF / 3
    req_stall = 0; rsp_lat = 4; r0 = n_req;
    push_exp(32'h55555555, 1'b1);
    send_cmd(8'h03, 16'd3);
    send_opnd(32'd100);
    send_opnd(32'd0);
    send_opnd(32'd3);
    wait_drain();
    chk("div_req_count", 32'(n_req - r0), 32'd1);
    chk("div_req_a", last_a, 32'hFFFFFFFF);
    chk("div_req_b", last_b, 32'd3);
    chk("div_req_div", 32'(last_div), 32'd1);

    // Unknown opcode drains its operands and reports an error
    push_exp(32'h00000000, 1'b1);
    send_cmd(8'h7F, 16'd2);
    send_opnd(32'h12345678);
    send_opnd(32'h9ABCDEF0);
    wait_drain();

    // Count zero gives an immediate empty result without consuming operands
    push_exp(32'h00000000, 1'b0);
    send_cmd(8'h01, 16'd0);
    chk("cnt0_opnd_ready", 32'(opnd_ready_o), 32'd0);
    chk("cnt0_res_valid", 32'(res_valid_o), 32'd1);
    wait_drain();

    // Result held under backpressure; pending command waits for the handshake
    push_exp(32'd3, 1'b0);
    push_exp(32'd0, 1'b0);
    send_cmd(8'h01, 16'd2);
    res_ready = 1'b0;
    send_opnd(32'd1);
    send_opnd(32'd2);
    chk("add2_latency_res_valid", 32'(res_valid_o), 32'd1);
    cmd_valid = 1'b1; cmd_op = 8'h01; cmd_count = 16'd0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1;
      chk("hold_res_valid", 32'(res_valid_o), 32'd1);
      chk("hold_res_data", res_data_o, 32'd3);
      chk("hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
    end
    res_ready = 1'b1;
    send_cmd(8'h01, 16'd0);
    wait_drain();

    // Reset while a MUL waits for its response drops the command
    rsp_lat = 20; r0 = n_req;
    send_cmd(8'h02, 16'd2);
    send_opnd(32'd3);
    send_opnd(32'd4);
    for (int k = 0; k < 50 && n_req == r0; k++) begin
      @(posedge clk_i); #1;
    end
    chk("rst_mul_req_seen", 32'(n_req - r0), 32'd1);
    repeat (3) @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    chk("midrst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    chk("midrst_res_valid", 32'(res_valid_o), 32'd0);
    chk("midrst_req_valid", 32'(req_valid_o), 32'd0);
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    chk("midrst_idle_cmd_ready", 32'(cmd_ready_o), 32'd1);
    rsp_lat = 4;
    repeat (25) @(posedge clk_i); #1;
    chk("midrst_no_result", 32'(res_valid_o), 32'd0);
    push_exp(32'd5, 1'b0);
    send_cmd(8'h01, 16'd2);
    send_opnd(32'd2);
    send_opnd(32'd3);
    wait_drain();

    repeat (3) @(posedge clk_i); #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Sequences one multi-operand ALU command: accepts an opcode and operand count, streams 32-bit operands, and folds them left-to-right into an accumulator. ADD is folded internally. MUL and DIV are issued one step at a time to an external shared iterative mul/div unit over a request/response handshake. Sits between the UART packet parser, which supplies commands and operands, and the UART TX serializer, which consumes the 32-bit result. It replaces the inline ADD/MUL/DIV states of the parser.

Parameters:
DATA_WIDTH, 32, operand/accumulator/result width
COUNT_WIDTH, 16, width of operand count

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when both high
cmd_op_i  in  8  opcode (opcode_e)
cmd_count_i  in  COUNT_WIDTH  number of operands in command
opnd_valid_i  in  1  operand valid
opnd_ready_o  out  1  operand accepted when both high
opnd_data_i  in  DATA_WIDTH  operand
req_valid_o  out  1  unit request valid
req_ready_i  in  1  unit accepts request
req_div_o  out  1  0=multiply, 1=unsigned divide
req_a_o  out  DATA_WIDTH  accumulator (multiplicand/dividend)
req_b_o  out  DATA_WIDTH  operand (multiplier/divisor)
rsp_valid_i  in  1  one-cycle response pulse
rsp_data_i  in  DATA_WIDTH  low product word or quotient
res_valid_o  out  1  result valid
res_ready_i  in  1  result consumed
res_data_o  out  DATA_WIDTH  result
res_err_o  out  1  error flag, qualified by res_valid_o

Behaviour:
- Reset: state IDLE; acc, remaining count, err and all outputs 0. cmd_ready_o=0 in the reset cycle and 1 on the first cycle after reset.
- States: IDLE, LOAD_FIRST, LOAD_NEXT, ISSUE, WAIT_RSP, DRAIN, RESULT.
- IDLE: cmd_ready_o=1. On accept, latch op and count and clear err.
  - count==0: go to RESULT with data 0, err 0.
  - Opcode not ADD/MUL/DIV: set err and go to DRAIN.
  - Otherwise: go to LOAD_FIRST.
- LOAD_FIRST: opnd_ready_o=1. On accept, acc=operand and remaining=count-1. If remaining==0, go to RESULT; else go to LOAD_NEXT.
- LOAD_NEXT: opnd_ready_o=1. On accept, decrement remaining.
  - ADD: acc=acc+operand mod 2^DATA_WIDTH, in the same cycle. Throughput is 1 operand/cycle.
  - MUL: latch operand into req_b and go to ISSUE.
  - DIV, operand==0: no request issued; acc=all-ones, err=1 (sticky), stay in the flow.
  - DIV, operand!=0: latch operand into req_b and go to ISSUE.
  - After the last operand, go to RESULT once any pending issue completes.
- ISSUE: req_valid_o=1. req_a/req_b/req_div are held stable until req_ready_i. On handshake, go to WAIT_RSP.
- WAIT_RSP: on rsp_valid_i, acc=rsp_data_i, then go to LOAD_NEXT, or to RESULT if remaining==0. rsp_valid_i is ignored in every other state. There is no timeout.
- DRAIN: opnd_ready_o=1. Consume exactly `count` operands, discarding them, then go to RESULT with data 0, err 1.
- RESULT: res_valid_o=1, res_data_o=acc, res_err_o=err. All are held stable until res_ready_i; on that handshake, go to IDLE.
- Backpressure: opnd_ready_o=0 outside LOAD_FIRST/LOAD_NEXT/DRAIN. cmd_ready_o=0 outside IDLE, so no new command is accepted until the result is consumed.
- Overflow: MUL keeps only the low DATA_WIDTH bits; no overflow flag. DIV is unsigned truncating.
- Simultaneous events: opnd_valid_i and cmd_valid_i may both be high. Only the handshake relevant to the current state fires.
- Reset mid-command: return to IDLE immediately and drop the partial result. The mul/div unit shares reset_i, so no stale response is delivered afterwards.
- Latency for a 2-operand ADD: result valid 1 cycle after the second operand is accepted. MUL/DIV: result valid 1 cycle after rsp_valid_i.

Decomposition:
- Shared package alu_pkg:
  - opcode_e: ECHO=8'hEC, ADD=8'h01, MUL=8'h02, DIV=8'h03.
  - Sequencer state enum.
  - DIV_BY_ZERO_RESULT constant (all ones).
- No sub-module needed. The mul/div unit stays external so it can be shared with other requesters.

Test Plan:
- ADD, count 3, operands 5, 7, 0xFFFFFFFF -> result 0x0000000B, err 0, 1 operand/cycle accepted.
- MUL, count 2, operands 0x10000, 0x10000, unit latency 8 with req_ready held low 3 cycles -> req_a/req_b stable throughout; result 0x00000000 (truncated), err 0.
- DIV, count 3, operands 100, 0, 3 -> no request for the zero divisor; acc=0xFFFFFFFF, then 0xFFFFFFFF/3; result 0x55555555, err 1.
- Opcode 0x7F, count 2 -> both operands drained; result 0, err 1. count 0 with ADD -> immediate result 0, err 0, no operand consumed.
- res_ready low 5 cycles -> result held; cmd_valid high throughout is not accepted until the result handshake.
- reset_i pulsed during WAIT_RSP of a MUL -> IDLE next cycle, no result emitted, next ADD 2+3 -> 5.
